// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: 2-flop synchroniser, 16x oversampling frame decoder and a
// first-word-fall-through byte FIFO with framing-error and overrun pulses.
module uart_rx_fifo #(
  parameter int BAUD_DIV   = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          Clk,
  input  logic                          rst,
  input  logic                          RX,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int TW = $clog2(BAUD_DIV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // ---------------- synchroniser and tick ----------------
  logic          sync1_q, sync2_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tick, rxs;

  assign rxs  = sync2_q;
  assign tick = (tcnt_q == TW'(BAUD_DIV - 1));

  always_comb begin
    tcnt_d = tick ? '0 : tcnt_q + TW'(1);
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      tcnt_q  <= '0;
    end else begin
      sync1_q <= RX;
      sync2_q <= sync1_q;
      tcnt_q  <= tcnt_d;
    end
  end

  // ---------------- frame decoder ----------------
  state_t     state_q, state_d;
  logic [3:0] sc_q, sc_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       push, ferr;

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr    = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_d = S_START;
            sc_d    = 4'd0;
          end
        end
        S_START: begin
          // Start bit must still be low at its midpoint, otherwise it was a glitch.
          if (sc_q == 4'd7) begin
            sc_d  = 4'd0;
            bit_d = 3'd0;
            state_d = rxs ? S_IDLE : S_DATA;
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
        S_DATA: begin
          if (sc_q == 4'd15) begin
            shift_d[bit_q] = rxs;
            sc_d = 4'd0;
            if (bit_q == 3'd7) state_d = S_STOP;
            else               bit_d   = bit_q + 3'd1;
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
        S_STOP: begin
          if (sc_q == 4'd15) begin
            sc_d = 4'd0;
            if (rxs) begin
              push    = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr    = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
        S_BREAK: begin
          if (rxs) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sc_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // ---------------- FWFT FIFO ----------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ferr_q, ovr_q, ovr_d;
  logic          pop, full, wr;

  assign pop  = (count_q != '0) && rx_ready;
  assign full = (count_q == CW'(FIFO_DEPTH));

  always_comb begin
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    wr       = push && (!full || pop);
    ovr_d    = push && full && !pop;
    wr_ptr_d = wr  ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr) - CW'(pop);
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ferr_q   <= ferr;
      ovr_q    <= ovr_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!rst && wr) mem_q[wr_ptr_q] <= shift_q;
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign rx_valid   = (count_q != '0);
  assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
